// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the round-robin APB master.
// The optional ACCESS timeout is enabled with the APB_TIMEOUT_EN macro.
package apb_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int SLV_W       = 2;
    localparam int NREQ_DEF    = 2;
    localparam int NSLV_DEF    = 2;
    localparam int AW_DEF      = 4;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping around.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gidx,
    output logic [IW-1:0]   nxt_ptr
);
    logic found;
    int   c;

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        c     = 0;
        for (int o = 0; o < NREQ; o++) begin
            c = (int'(ptr) + o) % NREQ;
            if (!found && req[c]) begin
                found = 1'b1;
                gidx  = IW'(c);
            end
        end
    end

    assign gnt     = (found && en) ? (NREQ'(1) << gidx) : '0;
    assign nxt_ptr = IW'((int'(gidx) + 1) % NREQ);
endmodule

// File: rtl/apb_rr_master_arb.sv
// Round-robin arbitrated APB master: NREQ requesters share one bus to NSLV slaves.
// Define APB_TIMEOUT_EN to abandon ACCESS after TIMEOUT cycles without pready.
module apb_rr_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int NSLV    = NSLV_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [SLV_W*NREQ-1:0] req_slv,
    input  logic [AW*NREQ-1:0]    req_addr,
    input  logic [DW*NREQ-1:0]    req_wdata,
    input  logic [NREQ-1:0]       req_wr,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic [NSLV-1:0]       psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [AW-1:0]         paddr,
    output logic [DW-1:0]         pwdata,
    input  logic [DW*NSLV-1:0]    prdata,
    input  logic [NSLV-1:0]       pready,
    input  logic [NSLV-1:0]       pslverr
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SLV_W-1:0] NSLV_V = SLV_W'(NSLV);

    state_t            state, nxt;
    logic [IW-1:0]     ptr, gidx, nxt_ptr;
    logic [NREQ-1:0]   gnt, gnt_q;
    logic              accept, bad_in, tmo;
    logic [SLV_W-1:0]  slv_in;
    logic [SLV_W-1:0]  slv_a   [NREQ];
    logic [AW-1:0]     addr_a  [NREQ];
    logic [DW-1:0]     wdata_a [NREQ];
    logic              sel_ready, sel_err;
    logic [DW-1:0]     sel_rdata;
    logic [NSLV-1:0]   psel_d;
    logic              penable_d, rsp_err_d;
    logic [NREQ-1:0]   rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign slv_a[i]   = req_slv[i*SLV_W +: SLV_W];
        assign addr_a[i]  = req_addr[i*AW +: AW];
        assign wdata_a[i] = req_wdata[i*DW +: DW];
    end

    // Gating with presetn keeps req_ready low while reset is held.
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (state == IDLE && presetn),
        .gnt     (gnt),
        .gidx    (gidx),
        .nxt_ptr (nxt_ptr)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign slv_in    = slv_a[gidx];
    assign bad_in    = (slv_in == '0) || (slv_in > NSLV_V);

    // psel is one-hot while a slave is addressed, so it doubles as the response mux select.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (psel[k]) begin
                sel_ready = sel_ready | pready[k];
                sel_err   = sel_err | pslverr[k];
                sel_rdata = sel_rdata | prdata[k*DW +: DW];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)              cnt <= '0;
        else if (state == SETUP)   cnt <= '0;
        else if (state == ACCESS)  cnt <= cnt + 1'b1;
    end

    assign tmo = (state == ACCESS) && !sel_ready && (cnt == CW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = bad_in ? RESP : SETUP;
            SETUP:   nxt = ACCESS;
            ACCESS:  if (sel_ready || tmo) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered below.
    always_comb begin
        psel_d      = '0;
        penable_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (nxt)
            SETUP: for (int k = 0; k < NSLV; k++) psel_d[k] = (slv_in == SLV_W'(k + 1));
            ACCESS: begin
                psel_d    = psel;
                penable_d = 1'b1;
            end
            RESP: begin
                rsp_valid_d = (state == IDLE) ? gnt : gnt_q;
                if (state == ACCESS && sel_ready) begin
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = pwrite ? '0 : sel_rdata;
                end else begin
                    rsp_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ptr       <= '0;
            gnt_q     <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
        end else begin
            psel      <= psel_d;
            penable   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            if (accept) begin
                ptr    <= nxt_ptr;
                gnt_q  <= gnt;
                paddr  <= addr_a[gidx];
                pwdata <= wdata_a[gidx];
                pwrite <= req_wr[gidx];
            end
        end
    end
endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Directed vector bench for apb_rr_master_arb with a small two-slave APB memory model.
module tb_apb_rr_master_arb;
    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  req_valid, req_ready, req_wr, rsp_valid, psel, pready, pslverr;
    logic [3:0]  req_slv;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata, prdata;
    logic [7:0]  rsp_rdata, pwdata;
    logic        rsp_err, penable, pwrite;
    logic [3:0]  paddr;

    int passed = 0;
    int total  = 0;

    apb_rr_master_arb #(.NREQ(2), .NSLV(2), .AW(4), .DW(8), .TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_slv(req_slv),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave model: wait_cfg wait states per access, err_cfg drives pslverr.
    logic [7:0] mem [2][16];
    int         wcnt [2];
    int         wait_cfg [2];
    logic [1:0] err_cfg;

    assign pslverr = err_cfg;
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            pready[k]        = (wcnt[k] == 0);
            prdata[k*8 +: 8] = mem[k][paddr];
        end
    end
    always @(posedge pclk) begin
        for (int k = 0; k < 2; k++) begin
            if (psel[k] && !penable) wcnt[k] <= wait_cfg[k];
            else if (psel[k] && penable && wcnt[k] != 0) wcnt[k] <= wcnt[k] - 1;
            if (psel[k] && penable && pready[k] && pwrite) mem[k][paddr] <= pwdata;
        end
    end

    typedef struct {
        int         r;
        logic [1:0] slv;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       wr;
        int         wt;
        logic       se;
        logic [1:0] exp_psel;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
        int         exp_pen;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_txn(input vec_t v);
        int n, pen, s;
        logic [1:0] oh;
        bit done;
        oh = 2'b01 << v.r;
        s  = int'(v.slv) - 1;
        wait_cfg[0] = 0; wait_cfg[1] = 0; err_cfg = 2'b00;
        if (s >= 0 && s < 2) begin
            wait_cfg[s] = v.wt;
            err_cfg[s]  = v.se;
        end
        @(negedge pclk);
        req_valid              = oh;
        req_slv[v.r*2 +: 2]    = v.slv;
        req_addr[v.r*4 +: 4]   = v.addr;
        req_wdata[v.r*8 +: 8]  = v.wdata;
        req_wr[v.r]            = v.wr;
        #1 chk("req_ready", 32'(req_ready), 32'(oh));
        @(posedge pclk);
        #1 req_valid = 2'b00;
        @(negedge pclk);
        chk("setup_psel_penable", {penable, psel}, {1'b0, v.exp_psel});
        n = 1; pen = 0; done = 0;
        while (!done && n < 40) begin
            if (penable) pen++;
            if (rsp_valid != 2'b00) done = 1;
            else begin
                n++;
                @(negedge pclk);
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("latency", n, v.exp_lat);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("penable_cycles", pen, v.exp_pen);
        @(negedge pclk);
        chk("rsp_one_cycle", 32'(rsp_valid), 0);
    endtask

    int         gq[$];
    logic [1:0] rq[$];
    logic [7:0] dq[$];
    int         exp_g [4] = '{0, 1, 0, 1};
    logic [1:0] exp_r [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_d [4] = '{8'h0F, 8'h32, 8'h0F, 8'h32};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          r slv  addr wdata  wr  wt se  psel   rdata  err lat pen
        vecs[0] = '{0, 2'd1, 4'd3, 8'h0F, 1'b1, 0, 1'b0, 2'b01, 8'h00, 1'b0, 3, 1};
        vecs[1] = '{0, 2'd2, 4'd5, 8'h32, 1'b1, 0, 1'b0, 2'b10, 8'h00, 1'b0, 3, 1};
        vecs[2] = '{1, 2'd1, 4'd3, 8'h00, 1'b0, 0, 1'b0, 2'b01, 8'h0F, 1'b0, 3, 1};
        vecs[3] = '{1, 2'd2, 4'd5, 8'h00, 1'b0, 0, 1'b0, 2'b10, 8'h32, 1'b0, 3, 1};
        vecs[4] = '{0, 2'd0, 4'd1, 8'h11, 1'b1, 0, 1'b0, 2'b00, 8'h00, 1'b1, 1, 0};
        vecs[5] = '{0, 2'd3, 4'd1, 8'h00, 1'b0, 0, 1'b0, 2'b00, 8'h00, 1'b1, 1, 0};
        vecs[6] = '{1, 2'd1, 4'd0, 8'hA5, 1'b1, 0, 1'b0, 2'b01, 8'h00, 1'b0, 3, 1};
        vecs[7] = '{0, 2'd1, 4'd0, 8'h00, 1'b0, 0, 1'b0, 2'b01, 8'hA5, 1'b0, 3, 1};
        vecs[8] = '{0, 2'd2, 4'd5, 8'h00, 1'b0, 3, 1'b1, 2'b10, 8'h32, 1'b1, 6, 4};

        wait_cfg[0] = 0; wait_cfg[1] = 0; err_cfg = 2'b00;
        req_valid = 2'b01; req_slv = 4'b0101; req_addr = '0; req_wdata = '0; req_wr = '0;
        presetn = 1'b0;
        #12;
        chk("reset_outputs",
            {req_ready, rsp_valid, rsp_err, rsp_rdata, psel, penable, pwrite, paddr, pwdata},
            '0);
        req_valid = 2'b00;
        @(negedge pclk);
        presetn = 1'b1;

        for (int i = 0; i < NV; i++) run_txn(vecs[i]);

`ifdef APB_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{0, 2'd2, 4'd5, 8'h00, 1'b0, 15, 1'b0, 2'b10, 8'h00, 1'b1, 6, 4};
            run_txn(tv);
        end
`endif

        // Contention: both requesters held valid from a reset pointer.
        @(negedge pclk);
        presetn = 1'b0;
        wait_cfg[0] = 0; wait_cfg[1] = 0; err_cfg = 2'b00;
        @(negedge pclk);
        presetn = 1'b1;
        req_slv = {2'd2, 2'd1}; req_addr = {4'd5, 4'd3}; req_wr = 2'b00;
        req_valid = 2'b11;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready != 2'b00) gq.push_back(req_ready[1] ? 1 : 0);
            if (rsp_valid != 2'b00) begin
                rq.push_back(rsp_valid);
                dq.push_back(rsp_rdata);
            end
            @(negedge pclk);
        end
        req_valid = 2'b00;
        chk("contention_grants", gq.size(), 4);
        chk("contention_rsps", rq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("contention_grant_order", gq[i], exp_g[i]);
            if (i < rq.size()) begin
                chk("contention_rsp_valid", 32'(rq[i]), 32'(exp_r[i]));
                chk("contention_rsp_rdata", 32'(dq[i]), 32'(exp_d[i]));
            end
        end
        repeat (4) @(negedge pclk);

        // Reset during ACCESS, then the pointer restarts at requester 0.
        wait_cfg[0] = 10; wait_cfg[1] = 0;
        req_slv[3:2] = 2'd1; req_addr[7:4] = 4'd3; req_wr[1] = 1'b0;
        req_valid = 2'b10;
        @(posedge pclk);
        #1 req_valid = 2'b00;
        for (int c = 0; c < 10 && !penable; c++) @(negedge pclk);
        chk("reached_access", 32'(penable), 1);
        #2 presetn = 1'b0;
        #1 chk("reset_mid_access", {rsp_valid, psel, penable}, 5'b0);
        @(negedge pclk);
        presetn = 1'b1;
        wait_cfg[0] = 0;
        req_slv = {2'd1, 2'd1}; req_addr = {4'd3, 4'd3};
        req_valid = 2'b11;
        #1 chk("post_reset_grant", 32'(req_ready), 32'b01);
        @(posedge pclk);
        #1 req_valid = 2'b00;
        repeat (5) @(negedge pclk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/apb_rr_master_arb.md
Name: apb_rr_master_arb

Overview:
- Round-robin arbitrated APB master that lets NREQ requesters share one APB bus to NSLV slaves.
- Each requester issues single read/write transactions through a valid/ready handshake. The block sequences APB SETUP/ACCESS phases and returns the read data and error flag to the requester that issued the transaction.
- Sits between the system-side command sources and the multi-slave APB fabric, replacing the single newd-driven master.

Parameters:
- NREQ, 2, number of requesters (2..4)
- NSLV, 2, number of APB slaves (1..3); slave index field is 2 bits, valid values 1..NSLV
- AW, 4, APB address width
- DW, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
- pclk  in  1  clock, rising edge
- presetn  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester transaction request
- req_ready  out  NREQ  one-hot accept strobe
- req_slv  in  2*NREQ  per-requester slave index (1..NSLV)
- req_addr  in  AW*NREQ  per-requester address
- req_wdata  in  DW*NREQ  per-requester write data
- req_wr  in  NREQ  1=write, 0=read
- rsp_valid  out  NREQ  one-hot, one-cycle completion strobe
- rsp_rdata  out  DW  read data; valid with rsp_valid
- rsp_err  out  1  error flag; valid with rsp_valid
- psel  out  NSLV  one-hot slave select; bit k selects slave k+1
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  AW  APB address
- pwdata  out  DW  APB write data
- prdata  in  DW*NSLV  per-slave read data
- pready  in  NSLV  per-slave ready
- pslverr  in  NSLV  per-slave error

Behaviour:
- Reset (async, presetn=0): all outputs 0, FSM=IDLE, RR pointer=0, captured request cleared. Takes effect immediately, including mid-transaction; no response is issued for an aborted transaction.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from pointer upward, with wrap-around.
  - Assert req_ready[g] combinationally in this cycle; the handshake completes in this cycle.
  - Latch slv/addr/wdata/wr.
  - Pointer <= (g+1) mod NREQ.
- Decode error: if the latched slv is 0 or >NSLV, go to RESP directly with err=1 and rdata=0. No APB activity.
- Otherwise go to SETUP.
- SETUP: psel[slv-1]=1, penable=0, paddr/pwrite/pwdata driven from latched values. Next state ACCESS unconditionally.
- ACCESS: psel held, penable=1.
  - Wait for pready[slv-1]; only the selected slave's pready/pslverr/prdata are used.
  - On pready: capture prdata (reads; 0 for writes) and pslverr; go to RESP.
- RESP:
  - rsp_valid[g]=1 for exactly one cycle with rsp_rdata/rsp_err.
  - psel=0, penable=0.
  - Next state IDLE. No new grant occurs in the RESP cycle.
- Latency: accept at cycle T; SETUP at T+1; ACCESS at T+2; with pready=1 at T+2, rsp_valid at T+3. Back-to-back grants occur every 4 cycles.
- paddr/pwrite/pwdata hold their values through SETUP and ACCESS and may hold stale values elsewhere. psel/penable are registered outputs.
- Requests arriving while busy are held by their sources; req_valid must stay high until req_ready.
- Simultaneous requests: strict rotation. A requester that was just granted is lowest priority next time.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: a counter is cleared on entry to ACCESS and increments each ACCESS cycle. If it reaches TIMEOUT without pready, the transaction is abandoned: psel/penable drop, then RESP with rsp_err=1 and rsp_rdata=0. If pready arrives in the same cycle the count reaches TIMEOUT, pready wins.
- Undefined: ACCESS waits indefinitely; no counter logic is present.

Decomposition:
- Package apb_arb_pkg:
  - state enum (IDLE/SETUP/ACCESS/RESP)
  - slave-index width constant (2)
  - default widths
- Sub-module rr_arbiter (NREQ):
  - inputs: request vector, pointer, enable
  - outputs: one-hot grant, grant index, next pointer
  - instantiated once.

Test Plan:
- Writes: req0 writes slv=1, addr=3, data=0x0F; then req0 writes slv=2, addr=5, data=0x32 (pready=1) -> psel=01/10 in SETUP+ACCESS, rsp_valid[0] at T+3 each, rsp_err=0.
- Read-back: req1 reads slv=1, addr=3 -> rsp_rdata=0x0F, rsp_err=0.
- Contention: req0 and req1 both valid continuously, pointer=0 -> grants alternate 0,1,0,1; each rsp_valid is one-hot to the correct requester.
- Decode error: req0 slv=0 and slv=3 (NSLV=2) -> no psel, rsp_err=1, rsp_rdata=0, rsp_valid at T+1 after accept.
- Slave error and wait states: slave 2 holds pready=0 for 3 cycles, then pready=1 with pslverr=1 -> penable held 4 cycles, rsp_err=1. With APB_TIMEOUT_EN and TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1.
- Reset mid-ACCESS: presetn=0 -> psel/penable/rsp_valid drop to 0 immediately; after release the next grant starts from requester 0.
